sevenseg_scan_decoder: RTL and testbench
========================================

// Module: sevenseg_scan_decoder
// PURPOSE
// - Reads a multiplexed, active-low 7-segment display bus and recovers each digit's 6-bit word
//   {blank, dp, nibble[3:0]}. This is the inverse of the hex-to-segment encoder.
// - Use cases: loopback checking of the display path on the board, and reading an external
//   7-segment module back into the design. Sits between the board pins and the status logic.
// PARAMETERS
// - NUM_DIGITS     4      digits on the bus; an_n width; min 1, max 8
// - SYNC_STAGES    2      synchroniser flops on every input; min 2
// - STABLE_CYCLES  8      consecutive identical samples needed to accept a digit; min 1
// - TIMEOUT_CYCLES 65536  staleness limit; used only with SEVENSEG_DEC_TIMEOUT_EN
// PORTS
// - clk          in   1              single clock
// - reset        in   1              asynchronous, active-high
// - segs_n       in   7              segments {a,b,c,d,e,f,g}, a = bit 6; active-low
// - dp_n         in   1              decimal point, active-low
// - an_n         in   NUM_DIGITS     digit enables, active-low; exactly one low = one digit driven
// - digits       out  6*NUM_DIGITS   digit i at [6i+5:6i] = {blank, dp, nibble}
// - digit_valid  out  NUM_DIGITS     bit i = digit i has been decoded at least once
// - upd          out  1              1-cycle pulse when any digit is written
// - upd_idx      out  3              index of the digit written; meaningful only while upd = 1
// - err          out  1              sticky flag: an illegal pattern was accepted
// - err_clr      in   1              clears err (synchronous)
// BEHAVIOUR
// - Reset: digits = 0, digit_valid = 0, upd = 0, upd_idx = 0, err = 0, synchronisers = all-ones
//   (idle bus), stability counter = 0, done = 0.
// - Sampling: every input passes through SYNC_STAGES flops. Sample S = {an_n, segs_n, dp_n} after sync.
// - Stability counter (cnt):
//   - If S != previous S: cnt = 1 and done = 0.
//   - Else: cnt saturates at STABLE_CYCLES.
// - Accept event: occurs when cnt reaches STABLE_CYCLES and done = 0, and ~an_n is one-hot. At that
//   edge, done is set; the next accept needs a change in S.
// - Non-one-hot an_n (none low, or several low): no accept. Counting continues, but stays inert.
// - Decode on accept:
//   - Lookup uses segs = ~segs_n against the 16 codes in sevenseg_pkg::SEG_LUT.
//   - Known code with dp_n = 0 or 1: word = {0, ~dp_n, code}.
//   - segs = 0 with dp_n = 1: word = {1, 0, 0000} (blank).
//   - Anything else, including segs = 0 with dp_n = 0: illegal. err <= 1, no digit write, upd = 0.
// - Write on a legal accept: digits[idx] <= word, digit_valid[idx] <= 1, upd = 1 for one cycle,
//   upd_idx = idx. upd and the write happen on the same edge.
// - Latency: an input change that then holds constant produces upd SYNC_STAGES + STABLE_CYCLES
//   cycles after the change reaches the pin flop.
// - Simultaneous err_clr and illegal accept: set wins, so err = 1.
// - Glitch shorter than STABLE_CYCLES: it restarts the count. After the glitch the original value
//   is accepted again, which rewrites the same word and asserts upd again. This is legal.
// - Asynchronous reset in mid-count: all state returns to reset values immediately.
// CONFIGURATION
// - Macro SEVENSEG_DEC_TIMEOUT_EN.
// - Defined:
//   - Each digit has a staleness counter. It clears on that digit's write and saturates at
//     TIMEOUT_CYCLES.
//   - On reaching TIMEOUT_CYCLES, digit_valid[i] <= 0 and digits[i] keeps its last value.
//   - A write in the same cycle as the timeout wins: valid stays 1.
// - Undefined: no timers exist, and digit_valid bits only clear on reset.
// STRUCTURE
// - Package sevenseg_pkg:
//   - SEG_LUT[16] (7-bit active-high patterns, the same table the encoder uses)
//   - typedef seg_word_t = struct packed {blank, dp, nibble[3:0]}
//   - function seg_decode(segs, dp_n) returning {legal, seg_word_t}
// - Sub-module: sevenseg_sync, a parameterised multi-bit synchroniser with async-high reset and
//   reset value = all ones.
// TESTING
// - Reset then idle (an_n = all ones): digits = 0, digit_valid = 0, upd never asserts,
//   err = 0 for 1000 cycles.
// - an_n = 1110, segs_n = ~7'b1111001 ("3"), dp_n = 0, held 20 cycles: exactly one upd with
//   upd_idx = 0; digits[5:0] = 6'b01_0011; digit_valid = 0001.
// - Scan 4 digits showing A,5,blank,F, 16 cycles each, 3 rounds: digits = {6'h0F,6'h20,6'h05,6'h0A}
//   (digit 3..0), digit_valid = 1111, 12 upd pulses.
// - Illegal code segs_n = ~7'b1010101, then err_clr pulse with an illegal accept on the same
//   edge: err stays 1 and no digit changes; a later lone err_clr gives err = 0.
// - Glitches and non-one-hot selects: 3-cycle glitch on segs_n (STABLE_CYCLES = 8) gives no
//   accept of the glitch value. an_n = 1100 held 50 cycles gives no upd and no err.
// - Timeout and reset (SEVENSEG_DEC_TIMEOUT_EN, TIMEOUT_CYCLES = 100):
//   - digit 1 written once, then the bus idles: digit_valid[1] clears exactly 100 cycles after
//     the write.
//   - reset asserted mid-count: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment lookup table, digit word type and decode helper
package sevenseg_pkg;

  // Active-high patterns {a,b,c,d,e,f,g}, a = bit 6; same table as the encoder
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] nibble;
  } seg_word_t;

  typedef struct packed {
    logic      legal;
    seg_word_t word;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] segs, input logic dp_n);
    seg_dec_t r;
    r = '0;
    if (segs == 7'h00) begin
      // Dark digit is only legal without a decimal point
      if (dp_n) begin
        r.legal      = 1'b1;
        r.word.blank = 1'b1;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (segs == SEG_LUT[i]) begin
          r.legal       = 1'b1;
          r.word.dp     = ~dp_n;
          r.word.nibble = 4'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sevenseg_sync.sv
// rtl/sevenseg_sync.sv - multi-bit flop synchroniser, resets to all ones (idle bus)
module sevenseg_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '1;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - recovers digit words from a scanned active-low 7-segment bus
// Optional per-digit staleness timeout: SEVENSEG_DEC_TIMEOUT_EN
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segs_n,
  input  logic                    dp_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [6*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int SW    = NUM_DIGITS + 8;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_counts
    $error("STABLE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  logic [SW-1:0]         w_s;
  logic [SW-1:0]         r_samp;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic [NUM_DIGITS-1:0] w_sel;
  logic                  w_onehot;
  logic [2:0]            w_idx;
  seg_dec_t              w_dec;
  logic                  w_accept;
  logic                  w_write;
  logic                  w_illegal;

  seg_word_t             r_digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_valid;
  logic                  r_upd;
  logic [2:0]            r_upd_idx;
  logic                  r_err;

  sevenseg_sync #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (reset),
    .i_d ({an_n, segs_n, dp_n}),
    .o_q (w_s)
  );

  // Decode always looks at the held sample, which is the value being timed
  assign w_sel    = ~r_samp[SW-1:8];
  assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_dec    = seg_decode(~r_samp[7:1], r_samp[0]);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  assign w_accept  = (r_cnt == CNT_W'(STABLE_CYCLES)) && !r_done && w_onehot;
  assign w_write   = w_accept && w_dec.legal;
  assign w_illegal = w_accept && !w_dec.legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_samp <= '1;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_s != r_samp) begin
      r_samp <= w_s;
      r_cnt  <= CNT_W'(1);
      r_done <= 1'b0;
    end else begin
      if (r_cnt != CNT_W'(STABLE_CYCLES)) r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_done <= 1'b1;
    end
  end

`ifdef SEVENSEG_DEC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_stale [NUM_DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_stale[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_write && w_idx == 3'(i)) r_stale[i] <= '0;
        else if (r_stale[i] != TMO_W'(TIMEOUT_CYCLES)) r_stale[i] <= r_stale[i] + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= '0;
      r_valid   <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_write && w_idx == 3'(i)) begin
          r_digits[i] <= w_dec.word;
          r_valid[i]  <= 1'b1;
        end
`ifdef SEVENSEG_DEC_TIMEOUT_EN
        // A write on the expiry edge takes the branch above, so it keeps valid set
        else if (r_stale[i] == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          r_valid[i] <= 1'b0;
        end
`endif
      end
      r_upd <= w_write;
      if (w_write) r_upd_idx <= w_idx;
      if (w_illegal) r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
    assign digits[6*g +: 6] = r_digits[g];
  end

  assign digit_valid = r_valid;
  assign upd         = r_upd;
  assign upd_idx     = r_upd_idx;
  assign err         = r_err;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - scoreboard bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

  localparam int ND = 4;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic [6:0]      segs_n  = 7'h7F;
  logic            dp_n    = 1'b1;
  logic [ND-1:0]   an_n    = '1;
  logic            err_clr = 1'b0;
  logic [6*ND-1:0] digits;
  logic [ND-1:0]   digit_valid;
  logic            upd;
  logic [2:0]      upd_idx;
  logic            err;

  int checks    = 0;
  int passed    = 0;
  int upd_count = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [5:0] word;
  } exp_t;

  exp_t sb [$];

  sevenseg_scan_decoder #(
    .NUM_DIGITS     (ND),
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segs_n      (segs_n),
    .dp_n        (dp_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [5:0] digit_of(input logic [2:0] i);
    return digits[int'(i)*6 +: 6];
  endfunction

  // Present one bus value for hold cycles; queue the word it must produce
  task automatic show(input logic [ND-1:0] an, input logic [6:0] sn, input logic dpn,
                      input int hold, input bit expect_upd, input logic [2:0] idx,
                      input logic [5:0] word);
    @(negedge clk);
    an_n   = an;
    segs_n = sn;
    dp_n   = dpn;
    if (expect_upd) sb.push_back({idx, word});
    repeat (hold - 1) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && upd) begin
        upd_count++;
        if (sb.size() == 0) begin
          chk("upd_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("upd_idx", 32'(upd_idx), 32'(e.idx));
          chk("upd_word", 32'(digit_of(upd_idx)), 32'(e.word));
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic [6*ND-1:0] snap;

    repeat (3) @(negedge clk);
    chk("reset_digits", digits, 0);
    chk("reset_valid", digit_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_upd", upd, 0);
    reset = 1'b0;

    repeat (1000) @(negedge clk);
    chk("idle_upd_count", upd_count, 0);
    chk("idle_digits", digits, 0);
    chk("idle_valid", digit_valid, 0);
    chk("idle_err", err, 0);

    show(4'b1110, ~7'h79, 1'b0, 20, 1'b1, 3'd0, 6'h13);
    chk("three_upd_count", upd_count, 1);
    chk("three_digit0", digits[5:0], 6'h13);
    chk("three_valid", digit_valid, 4'b0001);

    for (int r = 0; r < 3; r++) begin
      show(4'b1110, ~7'h77, 1'b1, 16, 1'b1, 3'd0, 6'h0A);
      show(4'b1101, ~7'h5B, 1'b1, 16, 1'b1, 3'd1, 6'h05);
      show(4'b1011, 7'h7F,  1'b1, 16, 1'b1, 3'd2, 6'h20);
      show(4'b0111, ~7'h47, 1'b1, 16, 1'b1, 3'd3, 6'h0F);
    end
    show(4'b1111, 7'h7F, 1'b1, 10, 1'b0, 3'd0, 6'h00);
    chk("scan_upd_count", upd_count, 13);
    chk("scan_digits", digits, {6'h0F, 6'h20, 6'h05, 6'h0A});
    chk("scan_valid", digit_valid, 4'b1111);

    snap = digits;
    show(4'b1110, ~7'h55, 1'b1, 16, 1'b0, 3'd0, 6'h00);
    chk("illegal_err", err, 1);
    chk("illegal_digits", digits, snap);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_alone_err", err, 0);
    // New illegal select; its accept lands on the edge where err_clr is high
    @(negedge clk); an_n = 4'b1101;
    repeat (10) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("set_wins_err", err, 1);
    chk("set_wins_digits", digits, snap);
    chk("illegal_upd_count", upd_count, 13);
    repeat (5) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_later_err", err, 0);

    show(4'b1011, ~7'h79, 1'b1, 16, 1'b1, 3'd2, 6'h03);
    show(4'b1011, 7'h00,  1'b1, 3,  1'b0, 3'd0, 6'h00);
    show(4'b1011, ~7'h79, 1'b1, 16, 1'b1, 3'd2, 6'h03);
    chk("glitch_upd_count", upd_count, 15);
    chk("glitch_digit2", digits[17:12], 6'h03);
    show(4'b1100, ~7'h79, 1'b1, 50, 1'b0, 3'd0, 6'h00);
    chk("nonhot_upd_count", upd_count, 15);
    chk("nonhot_err", err, 0);

`ifdef SEVENSEG_DEC_TIMEOUT_EN
    @(negedge clk);
    an_n = 4'b1101; segs_n = ~7'h30; dp_n = 1'b1;
    sb.push_back({3'd1, 6'h01});
    n = 0;
    while (!(upd && upd_idx == 3'd1) && n < 40) begin @(negedge clk); n++; end
    chk("tmo_write_seen", 32'(upd && upd_idx == 3'd1), 1);
    an_n = '1; segs_n = 7'h7F;
    n = 0;
    while (digit_valid[1] && n < 300) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, 100);
`endif

    n = upd_count;
    @(negedge clk);
    an_n = 4'b1110; segs_n = ~7'h4F; dp_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_nonzero", 32'(digits != '0), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_digits", digits, 0);
    chk("async_valid", digit_valid, 0);
    chk("async_upd", upd, 0);
    chk("async_upd_idx", upd_idx, 0);
    chk("async_err", err, 0);
    an_n = '1; segs_n = 7'h7F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_upd_count", upd_count, n);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
